// File: rtl/biquad_mac_sequencer.sv
// biquad_mac_sequencer: one lowpass biquad section built around a single shared multiply/add step, sequenced over four product cycles.
// Define BIQUAD_SAT_EN to saturate every rescaled product and add/subtract instead of wrapping.
module biquad_mac_sequencer #(
    parameter int W    = 39,
    parameter int FRAC = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] coef_a,
    input  logic signed [W-1:0] coef_b,
    input  logic signed [W-1:0] coef_c,
    input  logic signed [W-1:0] coef_d,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] y,
    output logic                busy
);
    typedef enum logic [2:0] {IDLE, MA, MB, MC, MD, DONE} state_t;
    state_t state_q, state_d;
    logic signed [W-1:0] x_q, x_d, a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic signed [W-1:0] acc_q, acc_d, w_q, w_d, w1_q, w1_d, w2_q, w2_d, y_q, y_d;
    logic ov_q, ov_d;
    logic signed [W-1:0] mul_p, mul_q, lhs, prod, sum1, sum2;
    logic signed [2*W-1:0] prod_full;
    logic sub_op;

    assign mul_p = state_q == MA ? a_q : state_q == MB ? b_q : state_q == MC ? c_q : d_q;
    assign mul_q = state_q == MA ? x_q : state_q == MC ? w2_q : w1_q;
    assign prod_full = mul_p * mul_q;
    assign lhs = state_q == MD ? w_q : acc_q;
    assign sub_op = state_q != MD;
`ifdef BIQUAD_SAT_EN
    localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
    function automatic logic signed [W-1:0] sat(input logic signed [2*W-1:0] v);
        return v > MAXV ? MAXV : v < MINV ? MINV : v[W-1:0];
    endfunction
    logic signed [W:0] sum1_full, sum2_full;
    assign prod = sat(prod_full >>> FRAC);
    assign sum1_full = sub_op ? (W+1)'(lhs) - (W+1)'(prod) : (W+1)'(lhs) + (W+1)'(prod);
    assign sum1 = sat((2*W)'(sum1_full));
    assign sum2_full = (W+1)'(sum1) + (W+1)'(w2_q);
    assign sum2 = sat((2*W)'(sum2_full));
`else
    // Arithmetic shift then keep the low W bits: just a slice of the full product.
    logic unused_prod_bits;
    assign prod = prod_full[W+FRAC-1:FRAC];
    assign unused_prod_bits = ^{prod_full[2*W-1:W+FRAC], prod_full[FRAC-1:0]};
    assign sum1 = sub_op ? lhs - prod : lhs + prod;
    assign sum2 = sum1 + w2_q;
`endif

    always_comb begin
        state_d = state_q;
        x_d = x_q;
        a_d = a_q;
        b_d = b_q;
        c_d = c_q;
        d_d = d_q;
        acc_d = acc_q;
        w_d = w_q;
        w1_d = w1_q;
        w2_d = w2_q;
        y_d = y_q;
        ov_d = ov_q;
        case (state_q)
            IDLE: if (in_valid) begin
                x_d = x;
                a_d = coef_a;
                b_d = coef_b;
                c_d = coef_c;
                d_d = coef_d;
                state_d = MA;
            end
            MA: begin
                acc_d = prod;
                state_d = MB;
            end
            MB: begin
                acc_d = sum1;
                state_d = MC;
            end
            MC: begin
                w_d = sum1;
                state_d = MD;
            end
            MD: begin
                y_d = sum2;
                ov_d = 1'b1;
                state_d = DONE;
            end
            DONE: if (out_ready) begin
                ov_d = 1'b0;
                w2_d = w1_q;
                w1_d = w_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Clear wins over acceptance and drops any in-flight sample.
        if (clr) begin
            state_d = IDLE;
            w1_d = '0;
            w2_d = '0;
            y_d = '0;
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q <= '0;
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
            d_q <= '0;
            acc_q <= '0;
            w_q <= '0;
            w1_q <= '0;
            w2_q <= '0;
            y_q <= '0;
            ov_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q <= x_d;
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
            d_q <= d_d;
            acc_q <= acc_d;
            w_q <= w_d;
            w1_q <= w1_d;
            w2_q <= w2_d;
            y_q <= y_d;
            ov_q <= ov_d;
        end
    end

    assign in_ready = state_q == IDLE;
    assign busy = state_q != IDLE;
    assign out_valid = ov_q;
    assign y = y_q;
endmodule

// File: doc/biquad_mac_sequencer.md
Name: biquad_mac_sequencer

Overview:
- Time-multiplexed controller for one second-order lowpass section: w = a*x - b*w1 - c*w2; y = w + d*w1 + w2.
- Replaces the four parallel multipliers with one shared multiply-accumulate step, sequenced by an FSM over four product cycles.
- Sits between a sample source and sink, with valid/ready handshakes on both sides; holds the two delay-line registers (w1, w2) internally.

Parameters:
- W, 39, signed data/coefficient word width (sign + 22 integer + 16 fraction).
- FRAC, 16, fractional bits; product is rescaled by an arithmetic right shift of FRAC.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of delay line and FSM.
- in_valid  in  1  sample and coefficients present.
- in_ready  out  1  block accepts a sample.
- x  in  W  input sample, signed fixed point.
- coef_a, coef_b, coef_c, coef_d  in  W each  section coefficients, signed fixed point.
- out_valid  out  1  y valid.
- out_ready  in  1  sink accepts y.
- y  out  W  filtered sample.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; w1=w2=acc=w_reg=0; y=0; out_valid=0; in_ready=1; busy=0.
- States: IDLE, MA, MB, MC, MD, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch x and the four coefficients, then go to MA. Unaccepted inputs are ignored.
- MA: acc <= P(coef_a, x). -> MB.
- MB: acc <= acc - P(coef_b, w1). -> MC.
- MC: w_reg <= acc - P(coef_c, w2). -> MD.
- MD: y <= w_reg + P(coef_d, w1) + w2; out_valid <= 1. -> DONE.
- DONE: hold y and out_valid stable while out_ready=0. On out_ready: out_valid <= 0, w2 <= w1, w1 <= w_reg, then go to IDLE.
- Latency: accept at cycle 0, out_valid high at cycle 5. Throughput: one sample per 6 cycles with out_ready tied high.
- in_ready=1 only in IDLE. A new input is never accepted in the same cycle as the output handshake.
- Product P(p, q): full 2W-bit signed product, arithmetic shift right by FRAC (rounds toward -inf), keep the low W bits.
- Add/subtract: W-bit two's complement, wrap-around on overflow (default build).
- Delay-line registers update only on the output handshake. Backpressure therefore never corrupts filter state.
- clr (synchronous, highest priority after reset): state=IDLE, w1=w2=0, out_valid=0, y=0. Any in-flight sample is dropped, including one waiting in DONE. clr together with in_valid in IDLE: the sample is not accepted.
- Coefficient or x changes after acceptance have no effect until the next acceptance.

Optional Feature:
- Macro BIQUAD_SAT_EN.
- Defined: every rescaled product and every add/subtract result saturates to +(2^(W-1)-1) or -2^(W-1) instead of wrapping. Saturation is applied per operation, in the order listed above.
- Undefined: wrap-around arithmetic, no saturation logic synthesized.
- Timing and handshake behaviour are identical in both builds.

Test Plan:
- Pass-through: a=65536, b=c=d=0; x = 196608, 327680, 0 -> y = 196608, 327680, 196608 (the w2 path delivers the first sample two samples later). out_valid rises exactly 5 cycles after each accept.
- Feedback impulse: a=65536, b=32768, c=d=0; x = 65536, 0, 0 -> w = 65536, -32768, 16384; y = 65536, -32768, 81920.
- Backpressure: out_ready=0 for 10 cycles in DONE -> y and out_valid stay stable, in_ready=0, and w1/w2 are unchanged until the handshake. The next sample's result matches the no-stall run.
- clr mid-operation: assert clr in MB, then run the impulse test -> identical outputs to a fresh post-reset run, and no out_valid pulse for the aborted sample.
- Async reset: drop rst_n in DONE -> out_valid=0, y=0, in_ready=1 immediately, before the next clk edge.
- Overflow: a = 2^(W-2) as a raw word, x = 4*65536 -> default build wraps to the truncated value. With BIQUAD_SAT_EN, y = 2^(W-1)-1.
